// File: rtl/recolector_sumas_if.sv
// ---------------------------------------------------------------------------
// recolector_sumas_if
// Bundle of the result-capture and consumer signals of recolector_sumas.
//   Producer side : valid_in, idx_in, sum_in   (results from the adder)
//   Consumer side : pop -> data_out/valid_out  (show-ahead FIFO head)
//   Status        : full, empty, count, total, overflow_err, underflow_err
// Modports:
//   master : bench/upstream side, drives valid_in/idx_in/sum_in/pop
//   slave  : the collector itself, drives data_out and all status signals
// ---------------------------------------------------------------------------
interface recolector_sumas_if #(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 4,
  parameter int IDX_W   = 4,
  parameter int TOTAL_W = 8
) ();

  logic                      valid_in;
  logic [IDX_W-1:0]          idx_in;
  logic [DATA_W-1:0]         sum_in;
  logic                      pop;
  logic [IDX_W+DATA_W-1:0]   data_out;
  logic                      valid_out;
  logic                      full;
  logic                      empty;
  logic [ADDR_W:0]           count;
  logic [TOTAL_W-1:0]        total;
  logic                      overflow_err;
  logic                      underflow_err;

  modport master (
    output valid_in, idx_in, sum_in, pop,
    input  data_out, valid_out, full, empty, count, total,
           overflow_err, underflow_err
  );

  modport slave (
    input  valid_in, idx_in, sum_in, pop,
    output data_out, valid_out, full, empty, count, total,
           overflow_err, underflow_err
  );

endinterface

// File: rtl/recolector_sumas.sv
// ---------------------------------------------------------------------------
// recolector_sumas
// Downstream collector of the pipelined 4-bit adder. Each valid (idx, sum)
// result is stored in a small FIFO and offered in order to a consumer with a
// show-ahead valid/pop handshake. A saturating running total of every
// accepted sum is kept alongside, plus sticky overflow/underflow flags.
// Ports:
//   clk   : single clock, all state changes on the rising edge
//   reset : synchronous, active-high; clears pointers, count, total, flags
//   bus   : recolector_sumas_if.slave (inputs valid_in/idx_in/sum_in/pop,
//           outputs data_out/valid_out/full/empty/count/total/err flags)
// ---------------------------------------------------------------------------
module recolector_sumas #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 4,
  parameter int IDX_W   = 4,
  parameter int TOTAL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  recolector_sumas_if.slave  bus
);

  localparam int                 ENTRY_W   = IDX_W + DATA_W;
  localparam logic [ADDR_W:0]    DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic               full, empty;
  logic               push_ok, pop_ok;
  logic [TOTAL_W:0]   total_sum;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    total_d     = total_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push when the consumer pops. Pop on an empty FIFO is simply ignored.
    push_ok = bus.valid_in && (!full || bus.pop);
    pop_ok  = bus.pop && !empty;

    // DEPTH is a power of two, so pointer wrap is the natural rollover.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // One extra bit catches the carry out; on carry the total pins at max.
    total_sum = {1'b0, total_q} + (TOTAL_W + 1)'(bus.sum_in);
    if (push_ok) begin
      total_d = total_sum[TOTAL_W] ? TOTAL_MAX : total_sum[TOTAL_W-1:0];
    end

    if (bus.valid_in && full && !bus.pop) overflow_d  = 1'b1;
    if (bus.pop && empty)                 underflow_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      total_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      total_q     <= total_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read once count says it was written, so its power-up value never shows.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= {bus.idx_in, bus.sum_in};
    end
  end

  // Show-ahead head: zero when nothing is stored, no same-cycle bypass.
  assign bus.data_out      = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.valid_out     = !empty;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.count         = count_q;
  assign bus.total         = total_q;
  assign bus.overflow_err  = overflow_q;
  assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_recolector_sumas.sv
// ---------------------------------------------------------------------------
// tb_recolector_sumas
// Directed bench for recolector_sumas. A queue-based reference model tracks
// the expected FIFO contents, running total and error flags; a compare
// process checks every DUT output against it on each falling edge, and
// literal expectations at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_recolector_sumas;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 2;
  localparam int DATA_W  = 4;
  localparam int IDX_W   = 4;
  localparam int TOTAL_W = 8;

  logic clk;
  logic reset;

  recolector_sumas_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W), .TOTAL_W(TOTAL_W)
  ) bus ();

  recolector_sumas #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .IDX_W(IDX_W), .TOTAL_W(TOTAL_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];
  int         m_total;
  bit         m_ovf, m_unf;
  bit         m_was_full, m_was_empty;
  bit         cmp_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_total = 0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      m_was_full  = (m_q.size() == DEPTH);
      m_was_empty = (m_q.size() == 0);
      if (bus.pop && m_was_empty)                  m_unf = 1'b1;
      if (bus.valid_in && m_was_full && !bus.pop)  m_ovf = 1'b1;
      if (bus.pop && !m_was_empty) void'(m_q.pop_front());
      if (bus.valid_in && (!m_was_full || bus.pop)) begin
        m_q.push_back({bus.idx_in, bus.sum_in});
        m_total = m_total + int'(bus.sum_in);
        if (m_total > 255) m_total = 255;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_data_out",  32'(bus.data_out), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
      check("m_valid_out", 32'(bus.valid_out), 32'(m_q.size() != 0));
      check("m_full",      32'(bus.full),  32'(m_q.size() == DEPTH));
      check("m_empty",     32'(bus.empty), 32'(m_q.size() == 0));
      check("m_count",     32'(bus.count), 32'(m_q.size()));
      check("m_total",     32'(bus.total), 32'(m_total));
      check("m_ovf",       32'(bus.overflow_err),  32'(m_ovf));
      check("m_unf",       32'(bus.underflow_err), 32'(m_unf));
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge: drive inputs, cross one rising edge, return at
  // the next falling edge with post-edge outputs settled.
  task automatic step(input logic v, input logic [3:0] i, input logic [3:0] s,
                      input logic p);
    bus.valid_in = v;
    bus.idx_in   = i;
    bus.sum_in   = s;
    bus.pop      = p;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] drain_exp [4];

  initial begin
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    bus.idx_in   = '0;
    bus.sum_in   = '0;
    bus.pop      = 1'b0;
    @(negedge clk);

    // Reset for two cycles while an input is offered; reset must win.
    step(1'b1, 4'h0, 4'hF, 1'b0);
    cmp_en = 1'b1;
    step(1'b1, 4'h0, 4'hF, 1'b0);
    reset = 1'b0;
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_total", 32'(bus.total), 0);
    check("rst_valid", 32'(bus.valid_out), 0);
    check("rst_data",  32'(bus.data_out), 0);
    check("rst_errs",  32'({bus.overflow_err, bus.underflow_err}), 0);

    // Fill: idx 1..4 with sums 3,5,7,9.
    step(1'b1, 4'd1, 4'd3, 1'b0);
    check("first_head", 32'(bus.data_out), 32'h13);
    check("first_valid", 32'(bus.valid_out), 1);
    step(1'b1, 4'd2, 4'd5, 1'b0);
    step(1'b1, 4'd3, 4'd7, 1'b0);
    step(1'b1, 4'd4, 4'd9, 1'b0);
    check("fill_full",  32'(bus.full), 1);
    check("fill_count", 32'(bus.count), 4);
    check("fill_total", 32'(bus.total), 24);
    check("fill_head",  32'(bus.data_out), 32'h13);

    // Overflow: push while full without pop is dropped.
    step(1'b1, 4'd5, 4'd2, 1'b0);
    check("ovf_flag",  32'(bus.overflow_err), 1);
    check("ovf_count", 32'(bus.count), 4);
    check("ovf_total", 32'(bus.total), 24);
    check("ovf_head",  32'(bus.data_out), 32'h13);

    // Full push+pop: head advances, new entry lands at the tail.
    step(1'b1, 4'd6, 4'd1, 1'b1);
    check("fpp_count", 32'(bus.count), 4);
    check("fpp_head",  32'(bus.data_out), 32'h25);
    check("fpp_total", 32'(bus.total), 25);

    // Drain in order; the dropped 0x52 must never appear.
    drain_exp[0] = 8'h25; drain_exp[1] = 8'h37;
    drain_exp[2] = 8'h49; drain_exp[3] = 8'h61;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_%0d", k), 32'(bus.data_out), 32'(drain_exp[k]));
      step(1'b0, 4'd0, 4'd0, 1'b1);
    end
    check("drain_empty", 32'(bus.empty), 1);
    check("drain_data",  32'(bus.data_out), 0);

    // Empty push+pop: push only, pop ignored, underflow flagged.
    step(1'b1, 4'd2, 4'd8, 1'b1);
    check("unf_flag",  32'(bus.underflow_err), 1);
    check("unf_count", 32'(bus.count), 1);
    check("unf_head",  32'(bus.data_out), 32'h28);
    check("unf_total", 32'(bus.total), 33);
    check("unf_ovf_sticky", 32'(bus.overflow_err), 1);

    // Saturation and pointer wrap: 40 pushes of 15 with continuous pop.
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 4'(k), 4'd15, 1'b1);
      check($sformatf("wrap_cnt_%0d", k), 32'(bus.count <= 3'd1), 1);
      check($sformatf("wrap_head_%0d", k), 32'(bus.data_out), 32'({4'(k), 4'd15}));
    end
    check("sat_total", 32'(bus.total), 255);
    step(1'b1, 4'd1, 4'd1, 1'b1);
    check("sat_hold", 32'(bus.total), 255);
    step(1'b0, 4'd0, 4'd0, 1'b1);
    check("sat_empty", 32'(bus.empty), 1);

    // Reset mid-operation discards stored entries and clears flags.
    step(1'b1, 4'd7, 4'd2, 1'b0);
    step(1'b1, 4'd8, 4'd3, 1'b0);
    reset = 1'b1;
    step(1'b1, 4'd9, 4'd4, 1'b0);
    reset = 1'b0;
    check("mrst_count", 32'(bus.count), 0);
    check("mrst_total", 32'(bus.total), 0);
    check("mrst_data",  32'(bus.data_out), 0);
    check("mrst_errs",  32'({bus.overflow_err, bus.underflow_err}), 0);
    step(1'b1, 4'd10, 4'd6, 1'b0);
    check("mrst_head",  32'(bus.data_out), 32'hA6);
    check("mrst_total2", 32'(bus.total), 6);
    step(1'b0, 4'd0, 4'd0, 1'b0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/recolector_sumas.md
Name: recolector_sumas

Overview:
- Downstream stage of the pipelined 4-bit adder; captures each (idx, sum) result pair the adder produces.
- Buffers pairs in a small FIFO, presents them in order to a consumer through a valid/pop interface, and keeps a saturating running total of accepted sums.
- Carries the index with its sum so the bench can match results against the issued idx.

Parameters:
DEPTH, 4, FIFO entries (power of two)
ADDR_W, 2, log2(DEPTH)
DATA_W, 4, width of sum_in
IDX_W, 4, width of idx_in
TOTAL_W, 8, width of running total

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset (sampled on rising edge of clk)
valid_in  input  1  sum_in/idx_in carry a valid result this cycle
idx_in  input  IDX_W  index of result (from adder idx_dd)
sum_in  input  DATA_W  sum value (from adder sum30_dd)
pop  input  1  consumer takes the head entry this cycle
data_out  output  IDX_W+DATA_W  head entry {idx, sum}
valid_out  output  1  data_out holds a valid entry (= !empty)
full  output  1  occupancy == DEPTH
empty  output  1  occupancy == 0
count  output  ADDR_W+1  occupancy 0..DEPTH
total  output  TOTAL_W  saturating sum of all accepted sum_in
overflow_err  output  1  sticky: push attempted while full without pop
underflow_err  output  1  sticky: pop asserted while empty

Behaviour:
- Reset (reset=1 at edge): rd/wr pointers=0, count=0, total=0, data_out=0, valid_out=0, empty=1, full=0, both err flags=0. Reset has priority over every other input. Reset mid-operation discards all stored entries.
- Push accepted when valid_in && (!full || pop). Entry {idx_in, sum_in} is written at wr_ptr, wr_ptr increments modulo DEPTH.
- Pop effective when pop && !empty. rd_ptr increments modulo DEPTH.
- Show-ahead output: data_out = mem[rd_ptr] while !empty, else 0. valid_out = !empty.
- Latency: an entry pushed into an empty FIFO at edge N appears on data_out with valid_out=1 in the cycle after edge N. There is no same-cycle bypass.
- count updates:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- full and empty derive from count.
- Simultaneous push+pop:
  - full: both occur, count stays DEPTH.
  - empty: push only, pop ignored, underflow_err set.
- Push when full without pop: entry dropped, state unchanged, overflow_err set.
- Error flags clear only on reset.
- total: on each accepted push, total <= min(total + zero-extended sum_in, 2^TOTAL_W-1). Saturates at 255 and holds. Dropped pushes do not add.
- Pointer wrap: after DEPTH pushes and pops, pointers return to 0. FIFO order is preserved across the wrap.

Test Plan:
- Reset: assert reset 2 cycles with valid_in=1, sum_in=4'hF -> count=0, empty=1, total=0, valid_out=0, data_out=0, errors=0.
- Fill/drain: push idx=1..4 with sum=3,5,7,9, no pop.
  - full=1, count=4, total=24, data_out=8'h13.
  - Then pop 4 cycles: data_out sequence 13,25,37,49, then empty=1.
- Overflow: FIFO full, push idx=5 sum=2 without pop -> overflow_err=1, count=4, total unchanged at 24, the entry is never output.
- Full push+pop: FIFO full, push idx=6 sum=1 with pop -> count stays 4, head advances, total=25, entry 8'h61 appears last after draining.
- Underflow and empty push+pop: FIFO empty, pop=1 with valid_in=1 idx=2 sum=8 -> underflow_err=1, count=1, data_out=8'h28 next cycle.
- Saturation and pointer wrap: stream 40 pushes of sum=15 with continuous pop.
  - total reaches 255 and holds.
  - Pointers wrap 10 times with no reordering.
  - count never exceeds 1.
